pwm_fade_ctrl: RTL
==================

PWM_FADE_CTRL -- requirements
Module: pwm_fade_ctrl

Interface
REQ-001 Parameter: PERIOD, 100, PWM period in clocks; 7-bit counter, legal range 2..127.
REQ-002 Port: clk  input  1  sole clock; all logic on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: req_valid  input  1  fade request present.
REQ-005 Port: req_ready  output  1  controller can accept a request.
REQ-006 Port: req_ch  input  2  target channel 0..3.
REQ-007 Port: req_duty  input  7  target duty in clocks-high per period.
REQ-008 Port: req_step  input  4  duty change per period.
REQ-009 Port: abort  input  1  cancel active fade; present only with PWM_FADE_ABORT_EN.
REQ-010 Port: cnt  output  7  period counter for the downstream PWM comparators.
REQ-011 Port: period_wrap  output  1  one-cycle strobe on each counter wrap.
REQ-012 Port: duty0..duty3  output  7 each  per-channel duty fed to the PWM comparators.
REQ-013 Port: busy  output  1  fade in progress.
REQ-014 Port: done  output  1  one-cycle pulse when a fade reaches its target.

Function
REQ-015 cnt SHALL count 0..PERIOD-1 and wrap to 0, advancing every cycle after reset.
REQ-016 period_wrap SHALL be registered and high exactly in the cycles where cnt has just wrapped PERIOD-1->0; it is low in the first cycle after reset.
REQ-017 FSM states SHALL be IDLE, RAMP and DONE.
REQ-018 req_ready SHALL equal (state==IDLE); busy SHALL equal (state==RAMP).
REQ-019 A request is accepted on a clock edge where req_valid&req_ready; req_valid while not ready is ignored, not queued.
REQ-020 On accept, the controller SHALL latch ch, target=min(req_duty,PERIOD) and step=(req_step==0)?1:req_step, then go to RAMP.
REQ-021 In RAMP, on each edge where cnt goes PERIOD-1->0, duty[ch] SHALL move toward target by step, saturating exactly at target with no overshoot or undershoot.
REQ-022 The updated duty SHALL be visible in the same cycle that period_wrap is high.
REQ-023 Duty arithmetic SHALL use 8-bit intermediates so that no 7-bit wrap-around occurs in either direction.
REQ-024 When duty[ch]==target in RAMP, including at entry, the FSM SHALL go to DONE on the next edge.
REQ-025 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-026 Non-addressed channels' duty values SHALL never change during a fade.

Reset
REQ-027 While rst=1 at an edge: cnt=0, period_wrap=0, duty0..3=0, state=IDLE, done=0, busy=0, latched request cleared.
REQ-028 Reset mid-RAMP SHALL discard the fade with no done pulse.
REQ-029 req_ready SHALL be 1 in the first cycle after reset release.

Configuration
REQ-030 Macro PWM_FADE_ABORT_EN defined: abort port exists; abort=1 in RAMP freezes duty[ch] at its current value and returns to IDLE next edge with no done pulse; abort in IDLE or DONE has no effect; abort and a wrap on the same edge apply abort and skip the step.
REQ-031 Macro PWM_FADE_ABORT_EN undefined: no abort port; a fade always runs to DONE.

Verification
REQ-032 Reset, then ch2 duty=50 step=10 -> duty2 reads 10,20,30,40,50 at successive period_wrap; done pulses once, the cycle after duty2 reaches 50; duty0/1/3 stay 0.
REQ-033 ch0 duty=25 step=10 -> duty0 = 10,20,25, no overshoot; then ch0 duty=5 step=15 -> duty0 = 10,5.
REQ-034 req_duty=120 step=0 on ch1 -> target clamps to 100, step of 1, 100 wraps to reach 100; a request issued mid-ramp sees req_ready=0 and is dropped.
REQ-035 ch3 duty equal to current duty 0 -> RAMP then DONE with no duty change, done within 2 cycles of accept.
REQ-036 rst asserted with duty1 at 40 mid-fade -> next cycle all duties 0, cnt 0, busy 0, no done.
REQ-037 With PWM_FADE_ABORT_EN: ch1 0->60 step 20, abort after duty1=40 -> duty1 holds 40, req_ready=1 next cycle, done never pulses.

Source files
------------

// File: rtl/pwm_fade_ctrl.sv
// PWM period counter plus per-channel duty fader for four channels.
// Optional abort input enabled by defining PWM_FADE_ABORT_EN.
module pwm_fade_ctrl #(
    parameter int unsigned PERIOD = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_ch,
    input  logic [6:0] req_duty,
    input  logic [3:0] req_step,
`ifdef PWM_FADE_ABORT_EN
    input  logic       abort,
`endif
    output logic [6:0] cnt,
    output logic       period_wrap,
    output logic [6:0] duty0,
    output logic [6:0] duty1,
    output logic [6:0] duty2,
    output logic [6:0] duty3,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAMP = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [6:0] LAST    = 7'(PERIOD - 1);
    localparam logic [6:0] TGT_MAX = 7'(PERIOD);

    state_t     state;
    logic [6:0] duty [4];
    logic [1:0] ch_q;
    logic [6:0] target_q;
    logic [3:0] step_q;

    logic       wrap_next;
    logic       abort_hit;
    logic [6:0] cur;
    logic [7:0] up8;
    logic [7:0] dn8;
    logic [6:0] next_duty;

    assign wrap_next = (cnt == LAST);

`ifdef PWM_FADE_ABORT_EN
    assign abort_hit = abort;
`else
    assign abort_hit = 1'b0;
`endif

    // 8-bit intermediates keep both directions free of 7-bit wrap-around
    always_comb begin
        cur       = duty[ch_q];
        up8       = {1'b0, cur} + {4'b0000, step_q};
        dn8       = {1'b0, cur} - {4'b0000, step_q};
        next_duty = cur;
        if (cur < target_q) begin
            next_duty = (up8 >= {1'b0, target_q}) ? target_q : up8[6:0];
        end else if (cur > target_q) begin
            next_duty = ({1'b0, cur} <= ({1'b0, target_q} + {4'b0000, step_q}))
                        ? target_q : dn8[6:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            period_wrap <= 1'b0;
            for (int unsigned i = 0; i < 4; i++) duty[i] <= '0;
            state       <= IDLE;
            ch_q        <= '0;
            target_q    <= '0;
            step_q      <= '0;
            done        <= 1'b0;
        end else begin
            cnt         <= wrap_next ? '0 : cnt + 7'd1;
            period_wrap <= wrap_next;
            done        <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        ch_q     <= req_ch;
                        target_q <= (req_duty > TGT_MAX) ? TGT_MAX : req_duty;
                        step_q   <= (req_step == 4'd0) ? 4'd1 : req_step;
                        state    <= RAMP;
                    end
                end
                RAMP: begin
                    if (abort_hit) begin
                        state <= IDLE;
                    end else if (duty[ch_q] == target_q) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else if (wrap_next) begin
                        duty[ch_q] <= next_duty;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready = (state == IDLE);
    assign busy      = (state == RAMP);
    assign duty0     = duty[0];
    assign duty1     = duty[1];
    assign duty2     = duty[2];
    assign duty3     = duty[3];

endmodule
